cache_ctrl_2way: RTL



---
 rtl/cache_ctrl_2way.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/cache_ctrl_2way.sv
// rtl/cache_ctrl_2way.sv - controller for a 2-way set-associative write-back write-allocate cache
//
// Purpose: sequences hit/miss handling between a pipeline memory stage, two
// cache-way arrays and a fixed-latency pipelined main memory. Picks a victim
// way on a miss, writes it back when dirty, refills the line, then completes
// the original access with a compare access.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   Rd, Wr, Addr, DataIn     request from the pipeline (held until Done)
//   Done, Stall, CacheHit    request status
//   DataOut                  read data, valid with Done
//   hit*/valid*/dirty*/tag*/c_dout*   per-way status and data from the arrays
//   en*, comp, c_wr, offset, c_din, valid_in   way array controls
//   mem_rd, mem_wr, mem_addr, mem_din, mem_dout  main memory port
//   err                      sticky error (Rd and Wr together, or double hit)
//   hit_cnt, miss_cnt        saturating access counters (CACHE_STATS_EN only)
//
// Optional feature macro: CACHE_STATS_EN
module cache_ctrl_2way #(
  parameter int DW         = 16,
  parameter int AW         = 16,
  parameter int TAG_W      = 5,
  parameter int LINE_WORDS = 4,
  parameter int MEM_LAT    = 2,
  localparam int OFF_W     = $clog2(LINE_WORDS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Rd,
  input  logic             Wr,
  input  logic [AW-1:0]    Addr,
  input  logic [DW-1:0]    DataIn,
  input  logic             hit0,
  input  logic             hit1,
  input  logic             valid0,
  input  logic             valid1,
  input  logic             dirty0,
  input  logic             dirty1,
  input  logic [TAG_W-1:0] tag0,
  input  logic [TAG_W-1:0] tag1,
  input  logic [DW-1:0]    c_dout0,
  input  logic [DW-1:0]    c_dout1,
  input  logic [DW-1:0]    mem_dout,
  output logic             Done,
  output logic             Stall,
  output logic             CacheHit,
  output logic [DW-1:0]    DataOut,
  output logic             en0,
  output logic             en1,
  output logic             comp,
  output logic             c_wr,
  output logic [OFF_W-1:0] offset,
  output logic [DW-1:0]    c_din,
  output logic             valid_in,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_din,
  output logic             err
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]      hit_cnt,
  output logic [15:0]      miss_cnt
`endif
);

  localparam int WI_W = OFF_W - 1;
  localparam int IX_W = AW - TAG_W - OFF_W;
  localparam int CW   = $clog2(LINE_WORDS + MEM_LAT + 1);
  localparam logic [CW-1:0] LW_C      = CW'(LINE_WORDS);
  localparam logic [CW-1:0] ML_C      = CW'(MEM_LAT);
  localparam logic [CW-1:0] WB_LAST   = CW'(LINE_WORDS - 1);
  localparam logic [CW-1:0] FILL_LAST = CW'(LINE_WORDS + MEM_LAT - 1);

  typedef enum logic [2:0] {IDLE, COMP, WB, FILL, FIN, ERR} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt;        // word counter shared by WB and FILL
  logic            vic;        // way chosen for the current miss
  logic            victimway;  // round-robin fallback when both ways are valid

  logic            hit_a, hit_b, miss_vic, miss_dirty;
  logic [TAG_W-1:0] vic_tag;
  logic [DW-1:0]   vic_dout;
  logic [WI_W-1:0] iss_idx, ret_idx;
  logic [IX_W-1:0] addr_idx;

  assign hit_a      = hit0 & valid0;
  assign hit_b      = hit1 & valid1;
  // Prefer an invalid way (way0 first); only fall back to victimway when both are valid.
  assign miss_vic   = valid0 ? (valid1 ? victimway : 1'b1) : 1'b0;
  assign miss_dirty = miss_vic ? (valid1 & dirty1) : (valid0 & dirty0);
  assign vic_tag    = vic ? tag1 : tag0;
  assign vic_dout   = vic ? c_dout1 : c_dout0;
  assign iss_idx    = cnt[WI_W-1:0];
  // FILL returns trail the issues by MEM_LAT cycles on the same counter.
  assign ret_idx    = WI_W'(cnt - ML_C);
  assign addr_idx   = Addr[AW-TAG_W-1:OFF_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      vic       <= 1'b0;
      victimway <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state)
        cnt <= '0;
      else if (state == WB || state == FILL)
        cnt <= cnt + CW'(1);
      if (state == COMP && (next_state == WB || next_state == FILL))
        vic <= miss_vic;
      if (Done)
        victimway <= ~victimway;
    end
  end

  always_comb begin
    next_state = state;
    Done       = 1'b0;
    Stall      = 1'b0;
    CacheHit   = 1'b0;
    DataOut    = '0;
    en0        = 1'b0;
    en1        = 1'b0;
    comp       = 1'b0;
    c_wr       = 1'b0;
    offset     = '0;
    c_din      = '0;
    valid_in   = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_din    = '0;
    err        = 1'b0;
    // Outputs are held at zero while rst is high so an abandoned operation
    // issues no further strobes in the reset cycle itself.
    if (!rst) begin
      case (state)
        IDLE: begin
          if (Rd && Wr)
            next_state = ERR;
          else if (Rd || Wr)
            next_state = COMP;
        end
        COMP: begin
          Stall  = 1'b1;
          en0    = 1'b1;
          en1    = 1'b1;
          comp   = 1'b1;
          c_wr   = Wr;
          offset = Addr[OFF_W-1:0];
          c_din  = DataIn;
          if (hit_a && hit_b) begin
            next_state = ERR;
          end else if (hit_a || hit_b) begin
            Done       = 1'b1;
            CacheHit   = 1'b1;
            DataOut    = hit_a ? c_dout0 : c_dout1;
            next_state = IDLE;
          end else begin
            next_state = miss_dirty ? WB : FILL;
          end
        end
        WB: begin
          Stall    = 1'b1;
          en0      = ~vic;
          en1      = vic;
          offset   = {iss_idx, 1'b0};
          mem_wr   = 1'b1;
          mem_addr = {vic_tag, addr_idx, iss_idx, 1'b0};
          mem_din  = vic_dout;
          if (cnt == WB_LAST)
            next_state = FILL;
        end
        FILL: begin
          Stall = 1'b1;
          if (cnt < LW_C) begin
            mem_rd   = 1'b1;
            mem_addr = {Addr[AW-1:OFF_W], iss_idx, 1'b0};
          end
          if (cnt >= ML_C) begin
            en0      = ~vic;
            en1      = vic;
            c_wr     = 1'b1;
            valid_in = 1'b1;
            offset   = {ret_idx, 1'b0};
            c_din    = mem_dout;
          end
          if (cnt == FILL_LAST)
            next_state = FIN;
        end
        FIN: begin
          Stall      = 1'b1;
          en0        = ~vic;
          en1        = vic;
          comp       = 1'b1;
          c_wr       = Wr;
          c_din      = DataIn;
          offset     = Addr[OFF_W-1:0];
          Done       = 1'b1;
          DataOut    = vic_dout;
          next_state = IDLE;
        end
        ERR: begin
          err = 1'b1;
        end
        default: next_state = IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (Done) begin
      if (CacheHit) begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
